// File: rtl/serial_io_responder_if.sv
// Byte-wide processor serial port plus host-link feed, grouped for serial_io_responder.
// master = processor/host side, slave = the responder.
interface serial_io_responder_if;
  logic [7:0] serial_out;
  logic       serial_wren_out;
  logic       serial_rden_out;
  logic [7:0] serial_in;
  logic       serial_valid_in;
  logic       serial_ready_in;
  logic [7:0] host_data_in;
  logic       host_valid_in;
  logic       host_ready_out;

  modport master (
    output serial_out, serial_wren_out, serial_rden_out, host_data_in, host_valid_in,
    input  serial_in, serial_valid_in, serial_ready_in, host_ready_out
  );

  modport slave (
    input  serial_out, serial_wren_out, serial_rden_out, host_data_in, host_valid_in,
    output serial_in, serial_valid_in, serial_ready_in, host_ready_out
  );
endinterface

// File: rtl/serial_io_responder.sv
// Device end of the processor serial port: TX FIFO feeding an 8N1 UART, RX FIFO fed by the host.
// Define SERIAL_TX_PARITY_EN to add an even-parity bit to each TX frame.
module serial_io_responder #(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  serial_io_responder_if.slave  bus,
  output logic                  tx_out,
  output logic                  tx_busy_out,
  output logic                  overflow_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];

  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          overflow_q, overflow_d;

  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic          rx_full, rx_empty, rx_push, rx_pop;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
`ifdef SERIAL_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif
  logic          tx_line;

  // FIFO bookkeeping; a same-cycle pop never frees the slot for a write.
  always_comb begin
    tx_full  = (tx_cnt_q == FULL_CNT);
    tx_empty = (tx_cnt_q == '0);
    rx_full  = (rx_cnt_q == FULL_CNT);
    rx_empty = (rx_cnt_q == '0);

    tx_push  = bus.serial_wren_out & ~tx_full;
    rx_push  = bus.host_valid_in & ~rx_full;
    rx_pop   = bus.serial_rden_out & ~rx_empty;

    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + AW'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + AW'(1) : tx_rd_ptr_q;
    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + AW'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + AW'(1) : rx_rd_ptr_q;

    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase

    overflow_d = overflow_q | (bus.serial_wren_out & tx_full);
  end

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= bus.serial_out;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= bus.host_data_in;
  end

  assign bus.serial_ready_in = ~tx_full;
  assign bus.host_ready_out  = ~rx_full;
  assign bus.serial_valid_in = ~rx_empty;
  assign bus.serial_in       = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    tx_pop   = 1'b0;
    tx_line  = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          shift_d  = tx_mem[tx_rd_ptr_q];
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^tx_mem[tx_rd_ptr_q];
`endif
          timer_d  = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        tx_line = 1'b0;
        if (timer_q == LAST_TICK) begin
          timer_d = '0;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DATA: begin
        tx_line = shift_q[0];
        if (timer_q == LAST_TICK) begin
          timer_d = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        tx_line = parity_q;
        if (timer_q == LAST_TICK) begin
          timer_d = '0;
          state_d = S_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif
      S_STOP: begin
        tx_line = 1'b1;
        if (timer_q == LAST_TICK) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level decodes straight from state so reset forces it high with no clock.
  assign tx_out       = tx_line;
  assign tx_busy_out  = (state_q != S_IDLE);
  assign overflow_out = overflow_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      overflow_q  <= 1'b0;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
`ifdef SERIAL_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_io_responder.sv
// Scoreboard bench for serial_io_responder: directed stimulus queues expected TX frames and RX bytes,
// independent monitors decode the UART line and RX pops and compare against those queues.
module tb_serial_io_responder;
  localparam int DEPTH = 8;
  localparam int CPB   = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tx_out, tx_busy_out, overflow_out;

  serial_io_responder_if bus ();

  serial_io_responder #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .tx_out       (tx_out),
    .tx_busy_out  (tx_busy_out),
    .overflow_out (overflow_out)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic mon_abort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge reset) mon_abort = 1'b1;

  // UART line monitor: samples each bit in its middle, compares against queued bytes.
  initial begin : uart_mon
    logic [7:0] d;
    logic [7:0] e;
    logic st, sp, p;
    p = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && tx_out == 1'b0) begin
        mon_abort = 1'b0;
        repeat (CPB / 2) @(negedge clock);
        st = tx_out;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          d[i] = tx_out;
        end
`ifdef SERIAL_TX_PARITY_EN
        repeat (CPB) @(negedge clock);
        p = tx_out;
`endif
        repeat (CPB) @(negedge clock);
        sp = tx_out;
        if (!mon_abort) begin
          if (tx_exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_unexpected: got frame 0x%02h, expected none", d);
          end else begin
            e = tx_exp_q.pop_front();
            check("tx_start_bit", st, 0);
            check("tx_data", d, e);
`ifdef SERIAL_TX_PARITY_EN
            check("tx_parity", p, ^e);
`endif
            check("tx_stop_bit", sp, 1);
            $display("tx frame: data 0x%02h parity %0b expected 0x%02h", d, p, e);
          end
        end
      end
    end
  end

  // RX pop monitor: every accepted read strobe must present the next queued host byte.
  initial begin : rx_mon
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (reset && bus.serial_rden_out && bus.serial_valid_in) begin
        if (rx_exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_unexpected: got 0x%02h, expected none", bus.serial_in);
        end else begin
          e = rx_exp_q.pop_front();
          check("rx_data", bus.serial_in, e);
          $display("rx pop: serial_in 0x%02h expected 0x%02h", bus.serial_in, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_tx(input logic [7:0] b);
    @(posedge clock); #1;
    bus.serial_out      = b;
    bus.serial_wren_out = 1'b1;
    @(posedge clock); #1;
    bus.serial_wren_out = 1'b0;
  endtask

  task automatic single_frame(input logic [7:0] b);
    int cnt;
    tx_exp_q.push_back(b);
    write_tx(b);
    @(negedge clock);
    check("lat_pre_tx", tx_out, 1);
    check("lat_pre_busy", tx_busy_out, 0);
    @(negedge clock);
    check("lat_post_tx", tx_out, 0);
    check("lat_post_busy", tx_busy_out, 1);
    cnt = 1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (!tx_busy_out) break;
      cnt++;
    end
    check("busy_len", cnt, FRAME_BITS * CPB);
    repeat (3) @(posedge clock);
  endtask

  task automatic rx_pops(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      bus.serial_rden_out = 1'b1;
    end
    @(posedge clock); #1;
    bus.serial_rden_out = 1'b0;
  endtask

  initial begin : main
    logic [7:0] rx_vals [3];
    logic [7:0] b;
    rx_vals = '{8'h11, 8'h22, 8'h33};
    bus.serial_out      = 8'h00;
    bus.serial_wren_out = 1'b0;
    bus.serial_rden_out = 1'b0;
    bus.host_data_in    = 8'h00;
    bus.host_valid_in   = 1'b0;

    #2;
    check("rst_tx_out", tx_out, 1);
    check("rst_busy", tx_busy_out, 0);
    check("rst_overflow", overflow_out, 0);
    check("rst_valid", bus.serial_valid_in, 0);
    check("rst_serial_in", bus.serial_in, 0);
    check("rst_ready", bus.serial_ready_in, 1);
    check("rst_host_ready", bus.host_ready_out, 1);
    #20;
    reset = 1'b1;
    repeat (2) @(posedge clock);

    single_frame(8'hA5);
    single_frame(8'h07);

    // Burst of 10 writes: 1 goes to the shifter, 8 fill the FIFO, the 10th is dropped.
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      b = 8'(8'h10 + i);
      bus.serial_out      = b;
      bus.serial_wren_out = 1'b1;
      if (i < 9) tx_exp_q.push_back(b);
      if (i == 9) begin
        check("ready_when_full", bus.serial_ready_in, 0);
        check("ovf_before_drop", overflow_out, 0);
      end
    end
    @(posedge clock); #1;
    bus.serial_wren_out = 1'b0;
    check("ovf_after_drop", overflow_out, 1);
    check("ready_still_full", bus.serial_ready_in, 0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (tx_exp_q.size() == 0 && !tx_busy_out) break;
    end
    check("tx_drain_left", tx_exp_q.size(), 0);
    check("ovf_sticky", overflow_out, 1);
    check("ready_after_drain", bus.serial_ready_in, 1);

    // RX ordering with back-to-back pops, then a read on empty.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      bus.host_data_in  = rx_vals[i];
      bus.host_valid_in = 1'b1;
      rx_exp_q.push_back(rx_vals[i]);
    end
    @(posedge clock); #1;
    bus.host_valid_in = 1'b0;
    check("rx_valid_loaded", bus.serial_valid_in, 1);
    check("rx_head_first", bus.serial_in, 8'h11);
    rx_pops(3);
    check("rx_valid_empty", bus.serial_valid_in, 0);
    check("rx_data_empty", bus.serial_in, 0);
    rx_pops(1);
    check("rx_valid_extra_pop", bus.serial_valid_in, 0);
    check("rx_data_extra_pop", bus.serial_in, 0);
    check("rx_ready_extra_pop", bus.host_ready_out, 1);

    // Fill RX, then push and pop together while full: only the pop happens.
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      b = 8'(8'h40 + i);
      bus.host_data_in  = b;
      bus.host_valid_in = 1'b1;
      rx_exp_q.push_back(b);
    end
    @(posedge clock); #1;
    bus.host_valid_in = 1'b0;
    check("rx_full_ready", bus.host_ready_out, 0);
    @(posedge clock); #1;
    bus.host_data_in    = 8'h99;
    bus.host_valid_in   = 1'b1;
    bus.serial_rden_out = 1'b1;
    @(posedge clock); #1;
    bus.host_valid_in   = 1'b0;
    bus.serial_rden_out = 1'b0;
    check("rx_ready_after_pop", bus.host_ready_out, 1);
    check("rx_head_after_pop", bus.serial_in, 8'h41);
    rx_pops(7);
    check("rx_valid_after_drain", bus.serial_valid_in, 0);
    check("rx_data_after_drain", bus.serial_in, 0);

    // Reset during data bit 3 of 0xC3 (bit 3 = 0), with one byte parked in RX.
    @(posedge clock); #1;
    bus.host_data_in  = 8'h55;
    bus.host_valid_in = 1'b1;
    @(posedge clock); #1;
    bus.host_valid_in = 1'b0;
    write_tx(8'hC3);
    repeat (18) @(posedge clock);
    #2;
    check("mid_bit3_tx", tx_out, 0);
    check("mid_busy", tx_busy_out, 1);
    check("mid_rx_valid", bus.serial_valid_in, 1);
    reset = 1'b0;
    #1;
    check("arst_tx_out", tx_out, 1);
    check("arst_busy", tx_busy_out, 0);
    check("arst_valid", bus.serial_valid_in, 0);
    check("arst_serial_in", bus.serial_in, 0);
    check("arst_ready", bus.serial_ready_in, 1);
    check("arst_host_ready", bus.host_ready_out, 1);
    check("arst_overflow", overflow_out, 0);
    #10;
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("post_rst_busy", tx_busy_out, 0);
    check("post_rst_tx_out", tx_out, 1);
    check("post_rst_valid", bus.serial_valid_in, 0);
    repeat (60) @(posedge clock);

    single_frame(8'h3C);

    check("tx_queue_left", tx_exp_q.size(), 0);
    check("rx_queue_left", rx_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
